// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and defaults for the instruction fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic        fault;
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer : 2-entry FIFO of fetch entries with push/pop/flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  fetch_entry_t i_push_entry,
   input  logic         i_pop,
   input  logic         i_flush,
   output logic [1:0]   o_count,
   output fetch_entry_t o_head
);

   fetch_entry_t r_mem [2];
   logic         r_rd;
   logic [1:0]   r_count;
   logic         w_wr_idx;

   // A flush empties the FIFO first, so a concurrent push lands in slot 0
   assign w_wr_idx = i_flush ? 1'b0 : (r_rd ^ r_count[0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd    <= 1'b0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_rd    <= 1'b0;
         r_count <= i_push ? 2'd1 : 2'd0;
      end else begin
         r_rd    <= r_rd ^ i_pop;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[w_wr_idx] <= i_push_entry;
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// inst_fetch_unit : PC owner and ROM fetch stage feeding decode via a 2-entry buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
   parameter int unsigned INST_MEM_SIZE = 256,
   parameter logic [31:0] NOP_INST      = NOP_INST_DEFAULT,
   parameter int unsigned BUF_DEPTH     = 2
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        rom_read_enable,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_fault
);

   localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
   localparam logic [1:0] ST_FETCH = 2'(S_FETCH);
   localparam logic [1:0] ST_FAULT = 2'(S_FAULT);

   logic [1:0]   r_state;
   logic [31:0]  r_pc;
   logic [1:0]   w_count;
   fetch_entry_t w_head;
   fetch_entry_t w_push_entry;
   logic         w_pop;
   logic         w_space;
   logic         w_in_range;
   logic         w_misaligned;
   logic         w_fetch_slot;
   logic         w_push;

   assign out_valid    = (w_count != 2'd0);
   assign w_pop        = out_valid && out_ready;
   assign w_space      = (w_count < 2'(BUF_DEPTH)) || w_pop;
   assign w_in_range   = (r_pc >> 2) < INST_MEM_SIZE;
   assign w_misaligned = (redirect_pc[1:0] != 2'b00);
   assign w_fetch_slot = (r_state == ST_FETCH) && !redirect_valid && w_space;

   assign rom_read_enable = w_fetch_slot && w_in_range;
   assign rom_addr        = r_pc;

   // A misaligned redirect still produces one fault marker so decode sees the trap
   assign w_push = redirect_valid ? w_misaligned : w_fetch_slot;

   always_comb begin
      w_push_entry.fault = 1'b0;
      w_push_entry.pc    = r_pc;
      w_push_entry.inst  = rom_inst;
      if (redirect_valid) begin
         w_push_entry.fault = 1'b1;
         w_push_entry.pc    = redirect_pc;
         w_push_entry.inst  = NOP_INST;
      end else if (!w_in_range) begin
         w_push_entry.fault = 1'b1;
         w_push_entry.inst  = NOP_INST;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc    <= redirect_pc;
         r_state <= w_misaligned ? ST_FAULT : ST_FETCH;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_FETCH;
            ST_FETCH: begin
               if (w_space) begin
                  if (w_in_range) begin
                     r_pc <= r_pc + 32'd4;
                  end else begin
                     r_state <= ST_FAULT;
                  end
               end
            end
            default: r_state <= r_state;
         endcase
      end
   end

   fetch_buffer u_fetch_buffer (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_flush      (redirect_valid),
      .o_count      (w_count),
      .o_head       (w_head)
   );

   assign out_inst  = out_valid ? w_head.inst : NOP_INST;
   assign out_pc    = out_valid ? w_head.pc   : 32'd0;
   assign out_fault = out_valid && w_head.fault;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// tb_inst_fetch_unit : randomized check of inst_fetch_unit against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RST_PC   = 32'h0000_0000;
   localparam int          MEM_SIZE = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rom_read_enable;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_fault;

   logic [31:0] rom_mem [MEM_SIZE];

   always #5 clk = ~clk;

   assign rom_inst = (rom_addr < 32'(MEM_SIZE * 4)) ? rom_mem[rom_addr[9:2]] : 32'hBAD0_BAD0;

   inst_fetch_unit u_dut (
      .clk             (clk),
      .rst             (rst),
      .rom_read_enable (rom_read_enable),
      .rom_addr        (rom_addr),
      .rom_inst        (rom_inst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_inst        (out_inst),
      .out_pc          (out_pc),
      .out_fault       (out_fault)
   );

   typedef struct {
      logic        f;
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        m_q[$];
   int          m_mode;    // 0 = bubble after reset, 1 = fetching, 2 = stopped
   logic [31:0] m_pc;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return (a >> 2) < 32'(MEM_SIZE);
   endfunction

   // One clock: drive at the falling edge, check just after, advance the model
   task automatic cyc(input logic rs, input logic rdy, input logic rv, input logic [31:0] rpc);
      ent_t h;
      ent_t e;
      bit   ev, pop, space, ren;
      @(negedge clk);
      rst            = rs;
      out_ready      = rdy;
      redirect_valid = rv && !rs;
      redirect_pc    = rpc;
      #1;
      if (rs) begin
         m_q.delete();
         m_mode = 0;
         m_pc   = RST_PC;
      end
      ev = (m_q.size() > 0);
      if (ev) h = m_q[0];
      else begin
         h.f = 1'b0; h.pc = 32'd0; h.inst = NOP;
      end
      pop   = ev && rdy;
      space = (m_q.size() < 2) || pop;
      ren   = !rs && (m_mode == 1) && !redirect_valid && space && in_range(m_pc);

      check_eq("out_valid", 64'(out_valid), 64'(ev));
      check_eq("out_pc",    64'(out_pc),    64'(h.pc));
      check_eq("out_inst",  64'(out_inst),  64'(h.inst));
      check_eq("out_fault", 64'(out_fault), 64'(h.f));
      check_eq("rom_ren",   64'(rom_read_enable), 64'(ren));
      check_eq("rom_addr",  64'(rom_addr),  64'(m_pc));

      if (!rs) begin
         if (pop) void'(m_q.pop_front());
         if (redirect_valid) begin
            m_q.delete();
            m_pc = rpc;
            if (rpc[1:0] != 2'b00) begin
               e.f = 1'b1; e.pc = rpc; e.inst = NOP;
               m_q.push_back(e);
               m_mode = 2;
            end else begin
               m_mode = 1;
            end
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1 && space) begin
            if (in_range(m_pc)) begin
               e.f = 1'b0; e.pc = m_pc; e.inst = rom_mem[m_pc[9:2]];
               m_q.push_back(e);
               m_pc = m_pc + 32'd4;
            end else begin
               e.f = 1'b1; e.pc = m_pc; e.inst = NOP;
               m_q.push_back(e);
               m_mode = 2;
            end
         end
      end
   endtask

   initial begin
      int          first;
      int          sel;
      logic [31:0] tgt;

      for (int i = 0; i < MEM_SIZE; i++) rom_mem[i] = $urandom();
      m_mode = 0;
      m_pc   = RST_PC;

      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'd0);

      // Release: bubble, fetch, then first valid
      first = -1;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 32'd0);
         if (out_valid && first < 0) first = i;
      end
      check_eq("first_valid_cycle", 64'(first), 64'd2);

      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 32'h40);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      cyc(1'b0, 1'b1, 1'b1, 32'h42);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      cyc(1'b0, 1'b1, 1'b1, 32'h3F0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
      check_eq("end_of_rom_ren", 64'(rom_read_enable), 64'd0);

      cyc(1'b0, 1'b1, 1'b1, 32'h0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0: tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            1: tgt = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            2: tgt = 32'h3F0 + 32'(4 * $urandom_range(0, 5));
            default: tgt = $urandom();
         endcase
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 15) == 0), tgt);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
